glitch_sweep_gen: RTL and testbench
===================================

Name: glitch_sweep_gen

Overview:
- Consumes the target power/reset pulse train produced by the upstream target-cycling stage.
- Arms on each rising edge of that signal, i.e. target power-up or release from reset.
- Waits a programmable number of clk cycles, then emits one glitch pulse of fixed width.
- Advances the delay by a fixed step per attempt, so repeated target cycles sweep the glitch offset across a window.
- glitch_out drives the crowbar/clock-glitch pin; attempt/wrap strobes feed status LEDs and a logger.

Parameters:
- DELAY_W, 32, width of delay counter and cur_delay.
- DELAY_START, 0, first delay value after reset and after each sweep wrap.
- DELAY_STEP, 1, increment applied to cur_delay after each completed attempt.
- DELAY_MAX, 1000, last delay value in the sweep window, inclusive.
- PULSE_WIDTH, 4, glitch_out high time in clk cycles; must be at least 1.

Ports:
- clk, input, 1, system clock; single clock domain.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, sweep enable; low forces IDLE.
- trig_in, input, 1, target power/reset level from the upstream stage; rising edge starts an attempt.
- glitch_out, output, 1, glitch pulse, active high.
- busy, output, 1, high in DELAY or PULSE.
- attempt_done, output, 1, one-cycle strobe after each pulse ends.
- sweep_wrap, output, 1, one-cycle strobe, coincident with attempt_done, when cur_delay wraps.
- cur_delay, output, DELAY_W, delay to be used by the next attempt.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - glitch_out, busy, attempt_done and sweep_wrap are 0.
  - cur_delay = DELAY_START.
  - The trig_in history register is 0.
- States:
  - IDLE -> ARMED when enable=1.
  - ARMED -> DELAY on a trig edge; the down-counter loads cur_delay.
  - DELAY: count reaches 0 -> PULSE; otherwise decrement the count.
  - PULSE: hold for PULSE_WIDTH cycles -> ARMED.
- Edge definition: trig_in=1 while the registered previous value is 0. The history register updates every cycle in every state.
- Latency: an edge sampled at clock edge E0 sets glitch_out high from edge E0+cur_delay+1. It stays high for exactly PULSE_WIDTH cycles.
- cur_delay=0 gives a pulse 1 cycle after the edge.
- glitch_out is registered, glitch-free, and high only in PULSE.
- End of attempt: on the cycle glitch_out falls, attempt_done=1 for one cycle, then cur_delay updates:
  - If cur_delay+DELAY_STEP > DELAY_MAX, compare at DELAY_W+1 bits so there is no overflow. cur_delay = DELAY_START and sweep_wrap=1.
  - Otherwise cur_delay += DELAY_STEP.
- Trigger edges arriving in DELAY or PULSE are ignored and not queued.
- An edge on the same cycle that PULSE returns to ARMED is ignored; the FSM is not yet armed.
- enable low in any state:
  - Next cycle: IDLE, glitch_out=0, busy=0.
  - No attempt_done.
  - cur_delay is unchanged, so the aborted delay is retried.
- enable high with trig_in already high does not trigger. A fresh rising edge is required.
- Mid-operation reset follows the reset values above; any pulse in progress is truncated immediately.

Optional Feature:
- Macro: GLITCH_TRIG_SYNC_EN.
- Defined:
  - trig_in passes through a 2-flop synchronizer before edge detection, for a trigger taken directly from a target pin.
  - Edge-to-pulse latency grows by 2 cycles, to cur_delay+3.
  - Synchronizer flops reset to 0.
- Undefined: trig_in is assumed same-domain and is used directly, with latency cur_delay+1.

Decomposition:
- Package glitch_pkg:
  - FSM state enum: IDLE, ARMED, DELAY, PULSE.
  - Default width constant for DELAY_W.
  - Pulse-width counter width, derived as clog2(PULSE_WIDTH+1).
- Sub-module trig_edge_detect:
  - Optional synchronizer plus previous-value register.
  - Outputs a single-cycle rise pulse.
- Top-level glitch_sweep_gen holds the FSM, counters and sweep arithmetic.

Test Plan (DELAY_START=5, DELAY_STEP=2, DELAY_MAX=9, PULSE_WIDTH=3 unless stated; macro off):
- Basic timing: reset, enable=1, trig_in rise sampled at E0 -> glitch_out high E6..E8 (3 cycles), attempt_done at the falling cycle, cur_delay becomes 7.
- Sweep and wrap: four trig_in rises -> pulses at offsets 6, 8, 10, then 6. sweep_wrap=1 together with the third attempt_done, and cur_delay returns to 5.
- Ignored re-trigger: second trig_in rise during DELAY, and another during PULSE -> exactly one pulse; attempt_done strobes once.
- Abort: enable low at E3 after the edge -> glitch_out never rises, no attempt_done, cur_delay still 5; re-enable and a fresh edge -> pulse at offset 6.
- Async reset during PULSE: rst_n low mid-pulse -> glitch_out 0 without waiting for clk; cur_delay=5 and state IDLE afterwards.
- Zero delay and sync: DELAY_START=0 -> pulse 1 cycle after the edge. With GLITCH_TRIG_SYNC_EN defined -> pulse 3 cycles after the edge.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared types and sizing helpers for the glitch sweep generator.
package glitch_pkg;

  localparam int unsigned DELAY_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    PULSE = 2'd3
  } state_e;

  // Width needed to hold a pulse-width count of 0..pw.
  function automatic int unsigned pcnt_width(input int unsigned pw);
    return $clog2(pw + 1);
  endfunction

endpackage

// File: rtl/glitch_sweep_gen_if.sv
// Control/status bundle between the glitch sweep generator and its driver.
interface glitch_sweep_gen_if
  import glitch_pkg::*;
#(
  parameter int unsigned DELAY_W = DELAY_W_DEF
);
  logic               enable;
  logic               trig_in;
  logic               glitch_out;
  logic               busy;
  logic               attempt_done;
  logic               sweep_wrap;
  logic [DELAY_W-1:0] cur_delay;

  modport master (
    output enable, trig_in,
    input  glitch_out, busy, attempt_done, sweep_wrap, cur_delay
  );

  modport slave (
    input  enable, trig_in,
    output glitch_out, busy, attempt_done, sweep_wrap, cur_delay
  );
endinterface

// File: rtl/trig_edge_detect.sv
// Rising-edge detector for the target power/reset level.
// GLITCH_TRIG_SYNC_EN inserts a 2-flop synchronizer ahead of the edge detect.
module trig_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_i,
  output logic rise_c
);
  logic trig_s;
  logic prev_q;

`ifdef GLITCH_TRIG_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], trig_i};
  end

  assign trig_s = sync_q[1];
`else
  assign trig_s = trig_i;
`endif

  // History updates every cycle regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= trig_s;
  end

  assign rise_c = trig_s & ~prev_q;
endmodule

// File: rtl/glitch_sweep_gen.sv
// Sweeping glitch generator: arms on trig rise, waits cur_delay, emits a fixed pulse.
// Optional macro GLITCH_TRIG_SYNC_EN synchronizes trig_in (adds 2 cycles of latency).
module glitch_sweep_gen
  import glitch_pkg::*;
#(
  parameter int unsigned DELAY_W     = DELAY_W_DEF,
  parameter int unsigned DELAY_START = 0,
  parameter int unsigned DELAY_STEP  = 1,
  parameter int unsigned DELAY_MAX   = 1000,
  parameter int unsigned PULSE_WIDTH = 4
)(
  input logic               clk,
  input logic               rst_n,
  glitch_sweep_gen_if.slave bus
);
  localparam int unsigned PCNT_W = pcnt_width(PULSE_WIDTH);

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic [DELAY_W-1:0] cur_delay_q, cur_delay_d;
  logic               glitch_q, glitch_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic               rise_c;
  logic [DELAY_W:0]   next_sum_c;
  logic               wrap_c;

  trig_edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .trig_i (bus.trig_in),
    .rise_c (rise_c)
  );

  // One extra bit so the window compare cannot overflow.
  assign next_sum_c = {1'b0, cur_delay_q} + (DELAY_W+1)'(DELAY_STEP);
  assign wrap_c     = next_sum_c > (DELAY_W+1)'(DELAY_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pcnt_q      <= '0;
      cur_delay_q <= DELAY_W'(DELAY_START);
      glitch_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pcnt_q      <= pcnt_d;
      cur_delay_q <= cur_delay_d;
      glitch_q    <= glitch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pcnt_d      = pcnt_q;
    cur_delay_d = cur_delay_q;
    done_d      = 1'b0;
    wrap_d      = 1'b0;

    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (rise_c) begin
            state_d = DELAY;
            cnt_d   = cur_delay_q;
          end
        end
        DELAY: begin
          if (cnt_q == '0) begin
            state_d = PULSE;
            pcnt_d  = PCNT_W'(PULSE_WIDTH - 1);
          end else begin
            cnt_d = cnt_q - DELAY_W'(1);
          end
        end
        PULSE: begin
          if (pcnt_q == '0) begin
            state_d = ARMED;
            done_d  = 1'b1;
            if (wrap_c) begin
              cur_delay_d = DELAY_W'(DELAY_START);
              wrap_d      = 1'b1;
            end else begin
              cur_delay_d = next_sum_c[DELAY_W-1:0];
            end
          end else begin
            pcnt_d = pcnt_q - PCNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Output flops follow the next state so glitch_out is high only in PULSE.
    glitch_d = (state_d == PULSE);
    busy_d   = (state_d == DELAY) || (state_d == PULSE);
  end

  assign bus.glitch_out   = glitch_q;
  assign bus.busy         = busy_q;
  assign bus.attempt_done = done_q;
  assign bus.sweep_wrap   = wrap_q;
  assign bus.cur_delay    = cur_delay_q;
endmodule

// File: tb/tb_glitch_sweep_gen.sv
// Directed scoreboard bench for glitch_sweep_gen (sweep instance plus a zero-delay instance).
module tb_glitch_sweep_gen;
  import glitch_pkg::*;

`ifdef GLITCH_TRIG_SYNC_EN
  localparam int unsigned S = 2;
`else
  localparam int unsigned S = 0;
`endif

  typedef struct {
    int unsigned rise_cyc;
    logic [31:0] next_delay;
    logic        wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en, en0, trig;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  glitch_sweep_gen_if #(.DELAY_W(32)) bus ();
  glitch_sweep_gen_if #(.DELAY_W(32)) bus0 ();

  assign bus.enable   = en;
  assign bus.trig_in  = trig;
  assign bus0.enable  = en0;
  assign bus0.trig_in = trig;

  glitch_sweep_gen #(.DELAY_W(32), .DELAY_START(5), .DELAY_STEP(2), .DELAY_MAX(9), .PULSE_WIDTH(3))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  glitch_sweep_gen #(.DELAY_W(32), .DELAY_START(0), .DELAY_STEP(2), .DELAY_MAX(9), .PULSE_WIDTH(3))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle trig pulse; optionally push the expected attempt outcome.
  task automatic trigger(input int unsigned offset, input logic [31:0] nd, input logic wr,
                         input bit push, output int unsigned e0);
    @(negedge clk);
    trig = 1'b1;
    e0   = cyc + 1;
    if (push) sb.push_back('{e0 + offset, nd, wr});
    @(negedge clk);
    trig = 1'b0;
  endtask

  // Wait for a pulse on the selected instance, pop and compare its expectations.
  task automatic collect(input bit sel, input bit poke, input string tag);
    exp_t e;
    int unsigned w;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sel ? bus0.glitch_out : bus.glitch_out) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (!seen) return;
    check({tag, "_rise_cyc"}, cyc, e.rise_cyc);
    w = 0;
    while ((sel ? bus0.glitch_out : bus.glitch_out) && w < 20) begin
      if (poke && w == 0) trig = 1'b1;
      if (poke && w == 1) trig = 1'b0;
      w++;
      @(negedge clk);
    end
    trig = 1'b0;
    check({tag, "_width"}, w, 32'd3);
    check({tag, "_done"}, 32'(sel ? bus0.attempt_done : bus.attempt_done), 32'd1);
    check({tag, "_wrap"}, 32'(sel ? bus0.sweep_wrap : bus.sweep_wrap), 32'(e.wrap));
    check({tag, "_busy"}, 32'(sel ? bus0.busy : bus.busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_clr"}, 32'(sel ? bus0.attempt_done : bus.attempt_done), 32'd0);
    check({tag, "_cur_delay"}, sel ? bus0.cur_delay : bus.cur_delay, e.next_delay);
  endtask

  task automatic quiet(input int n, input string tag);
    bit g, d;
    g = 1'b0;
    d = 1'b0;
    repeat (n) begin
      @(negedge clk);
      g |= bus.glitch_out;
      d |= bus.attempt_done;
    end
    check({tag, "_no_glitch"}, 32'(g), 32'd0);
    check({tag, "_no_done"}, 32'(d), 32'd0);
  endtask

  initial begin
    int unsigned e0;
    rst_n = 1'b0;
    en    = 1'b0;
    en0   = 1'b0;
    trig  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_glitch", 32'(bus.glitch_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.attempt_done), 32'd0);
    check("rst_wrap", 32'(bus.sweep_wrap), 32'd0);
    check("rst_cur_delay", bus.cur_delay, 32'd5);
    check("rst_cur_delay0", bus0.cur_delay, 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;

    // Zero delay on the second instance
    en0 = 1'b1;
    repeat (2) @(negedge clk);
    trigger(1 + S, 32'd2, 1'b0, 1'b1, e0);
    collect(1'b1, 1'b0, "zero");
    en0 = 1'b0;

    // Basic timing
    en = 1'b1;
    repeat (2) @(negedge clk);
    trigger(6 + S, 32'd7, 1'b0, 1'b1, e0);
    collect(1'b0, 1'b0, "basic");

    // Async reset in the middle of a pulse (cur_delay is 7 here)
    repeat (2) @(negedge clk);
    trigger(8 + S, 32'd0, 1'b0, 1'b0, e0);
    repeat (8 + S + 1) @(negedge clk);
    check("rst_mid_glitch_hi", 32'(bus.glitch_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_glitch", 32'(bus.glitch_out), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_cur_delay", bus.cur_delay, 32'd5);
    check("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Sweep through the window and wrap
    trigger(6 + S, 32'd7, 1'b0, 1'b1, e0);
    collect(1'b0, 1'b0, "sweep0");
    trigger(8 + S, 32'd9, 1'b0, 1'b1, e0);
    collect(1'b0, 1'b0, "sweep1");
    trigger(10 + S, 32'd5, 1'b1, 1'b1, e0);
    collect(1'b0, 1'b0, "sweep2");
    trigger(6 + S, 32'd7, 1'b0, 1'b1, e0);
    collect(1'b0, 1'b0, "sweep3");

    // Re-triggers during DELAY and PULSE are ignored
    trigger(8 + S, 32'd9, 1'b0, 1'b1, e0);
    repeat (2) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    collect(1'b0, 1'b1, "retrig");
    quiet(20, "retrig_after");

    // Abort by dropping enable three edges after the trigger edge
    trigger(10 + S, 32'd0, 1'b0, 1'b0, e0);
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_glitch", 32'(bus.glitch_out), 32'd0);
    quiet(15, "abort");
    check("abort_cur_delay", bus.cur_delay, 32'd9);
    en = 1'b1;
    repeat (2) @(negedge clk);
    trigger(10 + S, 32'd5, 1'b1, 1'b1, e0);
    collect(1'b0, 1'b0, "abort_retry");

    // Enabling while trig_in is already high must not start an attempt
    en = 1'b0;
    @(negedge clk);
    trig = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b1;
    quiet(15, "level_high");
    check("level_high_busy", 32'(bus.busy), 32'd0);
    trig = 1'b0;

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
